// File: rtl/seq_pulse_pkg.sv
// Shared types and constants for the sequential ring pulse generator.
// Mode and direction encodings match the raw values on the mode/dir pins.
package seq_pulse_pkg;

  typedef enum logic {
    SPG_IDLE = 1'b0,
    SPG_RUN  = 1'b1
  } spg_state_e;

  localparam logic MODE_CONT    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;
  localparam logic DIR_FWD      = 1'b0;
  localparam logic DIR_REV      = 1'b1;

endpackage : seq_pulse_pkg

// File: rtl/spg_dwell_timer.sv
// Per-phase dwell counter: counts 0..hold_eff-1 while enabled and flags the
// final cycle of the dwell so the owner can advance its phase.
module spg_dwell_timer #(
  parameter int HOLD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [HOLD_W-1:0] i_hold_eff,
  output logic              o_last
);

  logic [HOLD_W-1:0] r_cnt;
  logic              w_last;

  // hold_eff is never zero, so the subtraction cannot underflow
  assign w_last = (r_cnt == (i_hold_eff - HOLD_W'(1)));
  assign o_last = w_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (w_last) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + HOLD_W'(1);
      end
    end
  end

endmodule : spg_dwell_timer

// File: rtl/seq_pulse_gen.sv
// Sequential ring pulse generator: walks a one-hot pulse across N_CH channels,
// dwelling hold_eff cycles per phase, in continuous or one-shot mode.
module seq_pulse_gen
  import seq_pulse_pkg::*;
#(
  parameter  int N_CH   = 4,
  parameter  int HOLD_W = 8,
  localparam int PH_W   = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              en,
  input  logic              mode,
  input  logic              dir,
  input  logic [HOLD_W-1:0] hold_cyc,
  output logic [N_CH-1:0]   out,
  output logic [PH_W-1:0]   phase,
  output logic              busy,
  output logic              wrap,
  output logic              done
);

  spg_state_e        r_state;
  logic [PH_W-1:0]   r_phase;
  logic              r_mode;
  logic              r_dir;
  logic [HOLD_W-1:0] r_hold;
  logic [N_CH-1:0]   r_out;
  logic              r_busy;
  logic              r_wrap;
  logic              r_done;

  logic              w_run;
  logic              w_tmr_clr;
  logic              w_tmr_en;
  logic              w_last;
  logic              w_last_phase;
  logic [HOLD_W-1:0] w_hold_eff;

  function automatic logic [N_CH-1:0] phaseToOneHot(input logic [PH_W-1:0] ph,
                                                    input logic rev);
    logic [N_CH-1:0] v;
    v = '0;
    for (int i = 0; i < N_CH; i++) begin
      v[i] = rev ? (ph == PH_W'(i)) : (ph == PH_W'(N_CH - 1 - i));
    end
    return v;
  endfunction

  assign w_run        = (r_state == SPG_RUN);
  assign w_hold_eff   = (hold_cyc == '0) ? HOLD_W'(1) : hold_cyc;
  assign w_tmr_clr    = !w_run || stop;
  assign w_tmr_en     = w_run && en && !stop;
  assign w_last_phase = (r_phase == PH_W'(N_CH - 1));

  spg_dwell_timer #(
    .HOLD_W (HOLD_W)
  ) u_dwell (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_tmr_clr),
    .i_en       (w_tmr_en),
    .i_hold_eff (r_hold),
    .o_last     (w_last)
  );

  // wrap/done default low so they only ever pulse for a single cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= SPG_IDLE;
      r_phase <= '0;
      r_mode  <= MODE_CONT;
      r_dir   <= DIR_FWD;
      r_hold  <= HOLD_W'(1);
      r_out   <= '0;
      r_busy  <= 1'b0;
      r_wrap  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        SPG_IDLE: begin
          if (start && !stop) begin
            r_state <= SPG_RUN;
            r_phase <= '0;
            r_mode  <= mode;
            r_dir   <= dir;
            r_hold  <= w_hold_eff;
            r_out   <= phaseToOneHot('0, dir);
            r_busy  <= 1'b1;
          end
        end
        SPG_RUN: begin
          if (stop) begin
            r_state <= SPG_IDLE;
            r_phase <= '0;
            r_out   <= '0;
            r_busy  <= 1'b0;
          end else if (en && w_last) begin
            if (w_last_phase) begin
              r_wrap  <= 1'b1;
              r_phase <= '0;
              if (r_mode == MODE_ONESHOT) begin
                r_state <= SPG_IDLE;
                r_out   <= '0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_out <= phaseToOneHot('0, r_dir);
              end
            end else begin
              r_phase <= r_phase + PH_W'(1);
              r_out   <= phaseToOneHot(r_phase + PH_W'(1), r_dir);
            end
          end
        end
        default: begin
          r_state <= SPG_IDLE;
          r_phase <= '0;
          r_out   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign out   = r_out;
  assign phase = r_phase;
  assign busy  = r_busy;
  assign wrap  = r_wrap;
  assign done  = r_done;

endmodule : seq_pulse_gen

// File: tb/tb_seq_pulse_gen.sv
// Scoreboard bench: a 4-channel and a 5-channel generator share stimulus and
// are checked every cycle against an elapsed-tick reference model.
module tb_seq_pulse_gen;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       en;
  logic       mode;
  logic       dir;
  logic [7:0] hold_cyc;

  logic [3:0] out4;
  logic [1:0] phase4;
  logic       busy4, wrap4, done4;
  logic [4:0] out5;
  logic [2:0] phase5;
  logic       busy5, wrap5, done5;

  typedef struct {
    logic [4:0] out;
    logic [2:0] phase;
    logic       busy;
    logic       wrap;
    logic       done;
    string      tag;
  } exp_t;

  exp_t q4[$];
  exp_t q5[$];

  int checks = 0;
  int errors = 0;
  string scen = "init";

  // Reference model state per instance: run flag, ticks elapsed since launch
  bit mRun[2];
  int mTicks[2];
  int mHold[2];
  bit mMode[2];
  bit mDir[2];

  seq_pulse_gen #(.N_CH(4), .HOLD_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .en(en),
    .mode(mode), .dir(dir), .hold_cyc(hold_cyc),
    .out(out4), .phase(phase4), .busy(busy4), .wrap(wrap4), .done(done4)
  );

  seq_pulse_gen #(.N_CH(5), .HOLD_W(8)) dut5 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .en(en),
    .mode(mode), .dir(dir), .hold_cyc(hold_cyc),
    .out(out5), .phase(phase5), .busy(busy5), .wrap(wrap5), .done(done5)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clock of stimulus; the model predicts the state after the coming edge
  task automatic applyStimulus(input bit r, input bit st, input bit sp, input bit e,
                               input bit md, input bit dr, input int h);
    @(negedge clk);
    #1;
    rst_n    = r;
    start    = st;
    stop     = sp;
    en       = e;
    mode     = md;
    dir      = dr;
    hold_cyc = 8'(h);
    for (int k = 0; k < 2; k++) begin
      int   n;
      int   ph;
      exp_t ex;
      n  = (k == 0) ? 4 : 5;
      ex.wrap = 1'b0;
      ex.done = 1'b0;
      if (!r) begin
        mRun[k] = 1'b0;
      end else if (!mRun[k]) begin
        if (st && !sp) begin
          mRun[k]   = 1'b1;
          mTicks[k] = 0;
          mHold[k]  = (h == 0) ? 1 : h;
          mMode[k]  = md;
          mDir[k]   = dr;
        end
      end else if (sp) begin
        mRun[k] = 1'b0;
      end else if (e) begin
        mTicks[k]++;
        if (mTicks[k] == mHold[k] * n) begin
          ex.wrap = 1'b1;
          if (mMode[k]) begin
            ex.done = 1'b1;
            mRun[k] = 1'b0;
          end else begin
            mTicks[k] = 0;
          end
        end
      end
      ex.out = '0;
      if (mRun[k]) begin
        ph       = (mTicks[k] / mHold[k]) % n;
        ex.phase = 3'(ph);
        ex.busy  = 1'b1;
        ex.out[mDir[k] ? ph : (n - 1 - ph)] = 1'b1;
      end else begin
        ex.phase = '0;
        ex.busy  = 1'b0;
      end
      ex.tag = scen;
      if (k == 0) q4.push_back(ex);
      else        q5.push_back(ex);
    end
  endtask

  task automatic checkOutput(input string name, input exp_t ex, input logic [4:0] aOut,
                             input logic [2:0] aPh, input logic aBusy, input logic aWrap,
                             input logic aDone);
    checks++;
    if ({aOut, aPh, aBusy, aWrap, aDone} !== {ex.out, ex.phase, ex.busy, ex.wrap, ex.done}) begin
      errors++;
      $display("[TB] FAIL %s/%s at %0t: got out=%b phase=%0d busy=%b wrap=%b done=%b, expected out=%b phase=%0d busy=%b wrap=%b done=%b",
               name, ex.tag, $time, aOut, aPh, aBusy, aWrap, aDone,
               ex.out, ex.phase, ex.busy, ex.wrap, ex.done);
    end
  endtask

  // Monitor: every registered output cycle is one scoreboard transaction
  always @(negedge clk) begin
    if (q4.size() > 0) begin
      exp_t e4;
      e4 = q4.pop_front();
      checkOutput("n4", e4, {1'b0, out4}, {1'b0, phase4}, busy4, wrap4, done4);
    end
    if (q5.size() > 0) begin
      exp_t e5;
      e5 = q5.pop_front();
      checkOutput("n5", e5, out5, phase5, busy5, wrap5, done5);
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; en = 1'b1;
    mode = 1'b0; dir = 1'b0; hold_cyc = 8'd1;
    for (int k = 0; k < 2; k++) begin
      mRun[k] = 1'b0; mTicks[k] = 0; mHold[k] = 1; mMode[k] = 1'b0; mDir[k] = 1'b0;
    end

    scen = "reset";
    repeat (3) applyStimulus(0, 0, 0, 1, 0, 0, 1);
    repeat (2) applyStimulus(1, 0, 0, 1, 0, 0, 1);

    scen = "cont_fwd_h1";
    applyStimulus(1, 1, 0, 1, 0, 0, 1);
    repeat (12) applyStimulus(1, 0, 0, 1, 0, 0, 1);
    applyStimulus(1, 0, 1, 1, 0, 0, 1);
    applyStimulus(1, 0, 0, 1, 0, 0, 1);

    scen = "oneshot_rev_h3";
    applyStimulus(1, 1, 0, 1, 1, 1, 3);
    repeat (14) applyStimulus(1, 0, 0, 1, 1, 1, 3);
    repeat (2) applyStimulus(1, 0, 0, 1, 1, 1, 3);

    scen = "oneshot_h0";
    applyStimulus(1, 1, 0, 1, 1, 0, 0);
    repeat (6) applyStimulus(1, 0, 0, 1, 1, 0, 0);

    scen = "pause_ph2";
    applyStimulus(1, 1, 0, 1, 1, 1, 3);
    repeat (7) applyStimulus(1, 0, 0, 1, 1, 1, 3);
    repeat (5) applyStimulus(1, 0, 0, 0, 1, 1, 3);
    repeat (8) applyStimulus(1, 0, 0, 1, 1, 1, 3);

    scen = "stop_ph1";
    applyStimulus(1, 1, 0, 1, 0, 0, 3);
    repeat (4) applyStimulus(1, 0, 0, 1, 0, 0, 3);
    applyStimulus(1, 1, 1, 1, 0, 0, 3);
    repeat (2) applyStimulus(1, 0, 0, 1, 0, 0, 3);

    scen = "reset_ph2";
    applyStimulus(1, 1, 0, 1, 0, 0, 3);
    repeat (7) applyStimulus(1, 0, 0, 1, 0, 0, 3);
    applyStimulus(0, 0, 0, 1, 0, 0, 3);
    repeat (2) applyStimulus(1, 0, 0, 1, 0, 0, 3);

    scen = "cont_h2_restart";
    applyStimulus(1, 1, 0, 1, 0, 0, 2);
    repeat (12) applyStimulus(1, 0, 0, 1, 0, 0, 2);
    applyStimulus(1, 1, 0, 1, 1, 1, 5);
    repeat (12) applyStimulus(1, 0, 0, 1, 1, 1, 5);
    applyStimulus(1, 0, 1, 1, 0, 0, 2);
    applyStimulus(1, 0, 0, 1, 0, 0, 2);

    scen = "random";
    repeat (600) begin
      applyStimulus($urandom_range(0, 99) != 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 29) == 0, $urandom_range(0, 4) != 0,
                    1'($urandom), 1'($urandom), int'($urandom_range(0, 4)));
    end

    scen = "drain";
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (q4.size() + q5.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending entries, expected 0", q4.size() + q5.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_seq_pulse_gen
